// File: rtl/ysyx_210457_axi_rw_pkg.sv
// ysyx_210457_axi_rw_pkg: shared FSM state encoding, access-size and response codes, requester IDs and zero constants for the AXI read/write master
package ysyx_210457_axi_rw_pkg;
  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B, S_DONE} state_t;
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [3:0] ID_MEM = 4'b0001;
  localparam logic [3:0] ID_IF = 4'b0011;
  localparam logic [63:0] ZERO_WORD = 64'd0;
  localparam logic [31:0] ZERO_ADDR = 32'd0;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
endpackage

// File: rtl/ysyx_210457_axi_rw_if.sv
// ysyx_210457_axi_rw_if: single-beat AXI4 bus (AR/R/AW/W/B channels with handshakes and payloads); master modport drives requests, slave modport drives responses
interface ysyx_210457_axi_rw_if #(parameter int ADDR_W = 32, parameter int DATA_W = 64, parameter int ID_W = 4);
  logic ar_valid, ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic [ID_W-1:0] ar_id;
  logic [2:0] ar_size;
  logic [7:0] ar_len;
  logic [1:0] ar_burst;
  logic r_valid, r_ready;
  logic [DATA_W-1:0] r_data;
  logic [1:0] r_resp;
  logic aw_valid, aw_ready;
  logic [ADDR_W-1:0] aw_addr;
  logic [ID_W-1:0] aw_id;
  logic [2:0] aw_size;
  logic [7:0] aw_len;
  logic [1:0] aw_burst;
  logic w_valid, w_ready, w_last;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic b_valid, b_ready;
  logic [1:0] b_resp;
  modport master (
    output ar_valid, ar_addr, ar_id, ar_size, ar_len, ar_burst, r_ready,
    output aw_valid, aw_addr, aw_id, aw_size, aw_len, aw_burst,
    output w_valid, w_data, w_strb, w_last, b_ready,
    input ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
  );
  modport slave (
    input ar_valid, ar_addr, ar_id, ar_size, ar_len, ar_burst, r_ready,
    input aw_valid, aw_addr, aw_id, aw_size, aw_len, aw_burst,
    input w_valid, w_data, w_strb, w_last, b_ready,
    output ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
  );
endinterface

// File: rtl/ysyx_210457_axi_align.sv
// ysyx_210457_axi_align: byte-lane alignment; offset/size in, shifted write data + strobe out, read data right-shifted to LSB out
module ysyx_210457_axi_align (
  input  logic [2:0]  offset,
  input  logic [1:0]  size,
  input  logic [63:0] w_in,
  output logic [63:0] w_out,
  output logic [7:0]  w_strb,
  input  logic [63:0] r_in,
  output logic [63:0] r_out
);
  logic [15:0] mask;
  assign mask = (16'd1 << (5'd1 << size)) - 16'd1;
  assign w_strb = mask[7:0] << offset;
  assign w_out = w_in << {offset, 3'b000};
  assign r_out = r_in >> {offset, 3'b000};
endmodule

// File: rtl/ysyx_210457_axi_rw.sv
// ysyx_210457_axi_rw: single-outstanding AXI4 master; rw_* request/response from the arbiter, axi master bus to the interconnect
module ysyx_210457_axi_rw
  import ysyx_210457_axi_rw_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rw_valid,
  input  logic              rw_req,
  input  logic [ADDR_W-1:0] rw_addr,
  input  logic [DATA_W-1:0] rw_w_data,
  input  logic [1:0]        rw_size,
  input  logic [ID_W-1:0]   rw_id,
  output logic              rw_stall,
  output logic [DATA_W-1:0] rw_r_data,
  output logic [ID_W-1:0]   rw_out_id,
  output logic              rw_err,
  ysyx_210457_axi_rw_if.master axi
);
  state_t state, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q, rdata_q, r_shift;
  logic [1:0] size_q;
  logic [ID_W-1:0] id_q;
  logic err_q, aw_done, w_done, aw_done_n, w_done_n, aw_hs, w_hs;
  assign aw_hs = state == S_WR && !aw_done && axi.aw_ready;
  assign w_hs = state == S_WR && !w_done && axi.w_ready;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      addr_q <= ZERO_ADDR;
      data_q <= ZERO_WORD;
      size_q <= SIZE_B;
      id_q <= '0;
      rdata_q <= ZERO_WORD;
      err_q <= 1'b0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
    end else begin
      state <= state_n;
      aw_done <= aw_done_n;
      w_done <= w_done_n;
      if (state == S_IDLE && rw_valid) begin
        addr_q <= rw_addr;
        data_q <= rw_w_data;
        size_q <= rw_size;
        id_q <= rw_id;
      end
      if (state == S_R && axi.r_valid) begin
        rdata_q <= r_shift;
        err_q <= axi.r_resp != RESP_OKAY;
      end
      if (state == S_B && axi.b_valid) err_q <= axi.b_resp != RESP_OKAY;
    end
  end
  // AW and W complete independently; the flags remember which one is already done
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: state_n = rw_valid ? (rw_req ? S_WR : S_AR) : S_IDLE;
      S_AR:   state_n = axi.ar_ready ? S_R : S_AR;
      S_R:    state_n = axi.r_valid ? S_DONE : S_R;
      S_WR:   state_n = (aw_done || aw_hs) && (w_done || w_hs) ? S_B : S_WR;
      S_B:    state_n = axi.b_valid ? S_DONE : S_B;
      default: state_n = S_IDLE;
    endcase
    aw_done_n = state_n == S_WR && (aw_done || aw_hs);
    w_done_n = state_n == S_WR && (w_done || w_hs);
  end
  ysyx_210457_axi_align u_align (
    .offset(addr_q[2:0]),
    .size(size_q),
    .w_in(data_q),
    .w_out(axi.w_data),
    .w_strb(axi.w_strb),
    .r_in(axi.r_data),
    .r_out(r_shift)
  );
  assign axi.ar_valid = state == S_AR;
  assign axi.ar_addr = addr_q;
  assign axi.ar_id = id_q;
  assign axi.ar_size = {1'b0, size_q};
  assign axi.ar_len = AXI_LEN_SINGLE;
  assign axi.ar_burst = AXI_BURST_INCR;
  assign axi.r_ready = state == S_R;
  assign axi.aw_valid = state == S_WR && !aw_done;
  assign axi.aw_addr = addr_q;
  assign axi.aw_id = id_q;
  assign axi.aw_size = {1'b0, size_q};
  assign axi.aw_len = AXI_LEN_SINGLE;
  assign axi.aw_burst = AXI_BURST_INCR;
  assign axi.w_valid = state == S_WR && !w_done;
  assign axi.w_last = 1'b1;
  assign axi.b_ready = state == S_B;
  assign rw_stall = (state != S_IDLE && state != S_DONE) || (state == S_IDLE && rw_valid);
  assign rw_out_id = state == S_DONE ? id_q : '0;
  assign rw_err = state == S_DONE && err_q;
  assign rw_r_data = rdata_q;
endmodule
